// File: rtl/psum_readout_if.sv
// Output stream of the psum drain engine: requantized elements with
// valid/ready flow control and an end-of-frame marker.
interface psum_readout_if #(
  parameter int OUT_WIDTH = 8
);
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/psum_readout.sv
// Drain engine for the partial-sum buffer: walks every address in raster
// order, requantizes each sum and streams it out, then clears the buffer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, rd_addr parked at 0
// S_RUN   | loading one element per accepted slot, rd_addr advancing
// S_FLUSH | last element loaded, waiting for its handshake
// S_CLEAR | one-cycle psum_clear request, done follows next cycle
module psum_readout #(
  parameter int DATA_WIDTH = 24,
  parameter int H          = 12,
  parameter int W          = 11,
  parameter int ADDR_WIDTH = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 8,
  parameter int RELU       = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ce,
  input  logic                         start,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         psum_clear,
  output logic                         busy,
  output logic                         done,
  psum_readout_if.master               out_if
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_CLEAR} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H * W - 1);
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [DATA_WIDTH:0] RND =
    (SHIFT > 0) ? ((DATA_WIDTH + 1)'(1) << RSH) : '0;
  localparam logic signed [DATA_WIDTH:0] SAT_MAX =
    (DATA_WIDTH + 1)'((1 << (OUT_WIDTH - 1)) - 1);
  // ~x == -x-1, so this is the most negative representable output
  localparam logic signed [DATA_WIDTH:0] SAT_MIN = ~SAT_MAX;
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;

  logic signed [DATA_WIDTH:0] t_sum, t_sh, t_rl;
  logic [OUT_WIDTH-1:0]       rq_data;
  logic                       load;

  // Requantize the element at rd_addr: round half up, shift, ReLU, saturate
  always_comb begin
    t_sum = $signed({rd_data[DATA_WIDTH-1], rd_data}) + RND;
    t_sh  = t_sum >>> SHIFT;
    t_rl  = ((RELU != 0) && t_sh[DATA_WIDTH]) ? '0 : t_sh;
    if (t_rl > SAT_MAX) begin
      rq_data = OUT_MAX;
    end else if (t_rl < SAT_MIN) begin
      rq_data = OUT_MIN;
    end else begin
      rq_data = t_rl[OUT_WIDTH-1:0];
    end
  end

  // Next-state and datapath updates; everything holds while ce is low
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = done_q;
    load        = !out_valid_q || out_if.out_ready;
    if (ce) begin
      done_d = (state_q == S_CLEAR);
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_RUN;
            rd_addr_d = '0;
          end
        end
        S_RUN: begin
          if (load) begin
            out_data_d  = rq_data;
            out_valid_d = 1'b1;
            out_last_d  = (rd_addr_q == LAST_ADDR);
            if (rd_addr_q < LAST_ADDR) begin
              rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            end else begin
              state_d = S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (out_valid_q && out_if.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_CLEAR;
          end
        end
        S_CLEAR: begin
          state_d   = S_IDLE;
          rd_addr_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign rd_addr          = rd_addr_q;
  assign psum_clear       = (state_q == S_CLEAR) && ce;
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_psum_readout.sv
// Bench for psum_readout: two instances (ReLU off / on) share one stimulus;
// a scoreboard of requantized buffer contents checks every handshake.
module tb_psum_readout;
  localparam int DW = 24, H = 12, W = 11, AW = 8, OW = 8, SH = 8, N = H * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b1;

  always #5 clk = ~clk;

  logic [AW-1:0]        rd_addr0, rd_addr1;
  logic signed [DW-1:0] rd_data0, rd_data1;
  logic                 clr0, clr1, busy0, busy1, done0, done1;
  logic signed [DW-1:0] mem [0:255];

  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];

  psum_readout_if #(.OUT_WIDTH(OW)) if0 ();
  psum_readout_if #(.OUT_WIDTH(OW)) if1 ();
  assign if0.out_ready = ready;
  assign if1.out_ready = ready;

  psum_readout #(.DATA_WIDTH(DW), .H(H), .W(W), .ADDR_WIDTH(AW),
                 .OUT_WIDTH(OW), .SHIFT(SH), .RELU(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .rd_addr(rd_addr0),
    .rd_data(rd_data0), .psum_clear(clr0), .busy(busy0), .done(done0),
    .out_if(if0));

  psum_readout #(.DATA_WIDTH(DW), .H(H), .W(W), .ADDR_WIDTH(AW),
                 .OUT_WIDTH(OW), .SHIFT(SH), .RELU(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .psum_clear(clr1), .busy(busy1), .done(done1),
    .out_if(if1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference requantization: floor((v + 2^(SH-1)) / 2^SH), ReLU, clamp
  function automatic int rq(input int v, input bit relu);
    int t, q, d;
    d = 1 << SH;
    t = v + d / 2;
    if (t >= 0) q = t / d;
    else        q = -((-t + d - 1) / d);
    if (relu && q < 0) q = 0;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  typedef struct {
    int v0;
    int v1;
    bit last;
  } exp_t;

  exp_t expq[$];
  int   hs_count = 0;
  bit   clr_pending = 1'b0;
  bit   exp_done = 1'b0;
  bit   prev_hold = 1'b0;
  logic [OW-1:0] pd0, pd1;
  logic          pl0;
  logic [AW-1:0] pa0;

  // Per-cycle compare against the scoreboard and the hold/clear/done rules
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_hold   = 1'b0;
      clr_pending = 1'b0;
      exp_done    = 1'b0;
    end else begin
      chk("valid_lockstep", int'(if1.out_valid), int'(if0.out_valid));
      if (prev_hold) begin
        chk("hold_data0", int'(if0.out_data), int'(pd0));
        chk("hold_data1", int'(if1.out_data), int'(pd1));
        chk("hold_last", int'(if0.out_last), int'(pl0));
        chk("hold_addr", int'(rd_addr0), int'(pa0));
      end
      chk("psum_clear", int'(clr0), int'(clr_pending && ce));
      chk("psum_clear1", int'(clr1), int'(clr0));
      if (clr0) clr_pending = 1'b0;
      chk("done", int'(done0), int'(exp_done));
      chk("done1", int'(done1), int'(done0));
      exp_done = clr0 || (done0 && !ce);
      if (ce && if0.out_valid && ready) begin
        if (expq.size() == 0) begin
          chk("extra_output", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("data_relu0", int'($signed(if0.out_data)), e.v0);
          chk("data_relu1", int'($signed(if1.out_data)), e.v1);
          chk("last", int'(if0.out_last), int'(e.last));
          if (e.last) clr_pending = 1'b1;
        end
        hs_count++;
      end
      prev_hold = if0.out_valid && !(ce && ready);
      pd0 = if0.out_data;
      pd1 = if1.out_data;
      pl0 = if0.out_last;
      pa0 = rd_addr0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    expq.delete();
    hs_count = 0;
    for (int k = 0; k < N; k++)
      expq.push_back('{rq(int'(mem[k]), 1'b0), rq(int'(mem[k]), 1'b1), k == N - 1});
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 3000 && hs_count < n; i++) cyc();
    chk("wait_hs_timeout", int'(hs_count >= n), 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !done0; i++) cyc();
    chk("done_timeout", int'(done0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = DW'(256 * k);

    // Model pins
    chk("model_384", rq(384, 1'b0), 2);
    chk("model_m384", rq(-384, 1'b0), -1);
    chk("model_m384_relu", rq(-384, 1'b1), 0);
    chk("model_m40000", rq(-40000, 1'b0), -128);

    // Reset state
    #1;
    chk("rst_addr", int'(rd_addr0), 0);
    chk("rst_valid", int'(if0.out_valid), 0);
    chk("rst_data", int'(if0.out_data), 0);
    chk("rst_last", int'(if0.out_last), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_busy", int'(busy0), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Test 1: ramp 256*k, full drain, first-output latency
    do_start();
    chk("t1_busy", int'(busy0), 1);
    chk("t1_valid_early", int'(if0.out_valid), 0);
    cyc();
    chk("t1_first_valid", int'(if0.out_valid), 1);
    chk("t1_first_data", int'($signed(if0.out_data)), 0);
    chk("t1_addr_after_first", int'(rd_addr0), 1);
    wait_done();
    chk("t1_count", hs_count, N);
    chk("t1_idle", int'(busy0), 0);

    // Test 2: rounding/ReLU/saturation corners, started back-to-back with done
    mem[0] = 24'sd384;
    mem[1] = -24'sd384;
    mem[2] = 24'sd40000;
    mem[3] = -24'sd40000;
    do_start();
    cyc();
    chk("t2_e0_r0", int'($signed(if0.out_data)), 2);
    chk("t2_e0_r1", int'($signed(if1.out_data)), 2);
    cyc();
    chk("t2_e1_r0", int'($signed(if0.out_data)), -1);
    chk("t2_e1_r1", int'($signed(if1.out_data)), 0);
    cyc();
    chk("t2_e2_r0", int'($signed(if0.out_data)), 127);
    chk("t2_e2_r1", int'($signed(if1.out_data)), 127);
    cyc();
    chk("t2_e3_r0", int'($signed(if0.out_data)), -128);
    chk("t2_e3_r1", int'($signed(if1.out_data)), 0);
    wait_done();
    chk("t2_count", hs_count, N);
    for (int k = 0; k < 4; k++) mem[k] = DW'(256 * k);

    // Test 3: stall on element 5 for two extra cycles
    do_start();
    wait_hs(5);
    ready = 1'b0;
    chk("t3_stall_data_a", int'($signed(if0.out_data)), 5);
    chk("t3_stall_addr_a", int'(rd_addr0), 6);
    cyc();
    chk("t3_stall_data_b", int'($signed(if0.out_data)), 5);
    cyc();
    chk("t3_stall_data_c", int'($signed(if0.out_data)), 5);
    chk("t3_stall_addr_c", int'(rd_addr0), 6);
    ready = 1'b1;
    cyc();
    chk("t3_next_data", int'($signed(if0.out_data)), 6);
    wait_done();
    chk("t3_count", hs_count, N);

    // Test 4: start while busy is ignored
    cyc();
    cyc();
    do_start();
    wait_hs(40);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t4_busy", int'(busy0), 1);
    wait_done();
    chk("t4_count", hs_count, N);

    // Test 5: async reset mid-drain
    cyc();
    do_start();
    wait_hs(60);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_addr", int'(rd_addr0), 0);
    chk("t5_valid", int'(if0.out_valid), 0);
    chk("t5_data", int'(if0.out_data), 0);
    chk("t5_last", int'(if0.out_last), 0);
    chk("t5_busy", int'(busy0), 0);
    chk("t5_clear", int'(clr0), 0);
    expq.delete();
    cyc();
    chk("t5_clear_b", int'(clr0), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t5_idle", int'(busy0), 0);
    chk("t5_idle_valid", int'(if0.out_valid), 0);

    // Test 6: fresh drain from addr 0 with ce low for 4 cycles
    do_start();
    cyc();
    chk("t6_first_data", int'($signed(if0.out_data)), 0);
    chk("t6_first_addr", int'(rd_addr0), 1);
    wait_hs(20);
    ce = 1'b0;
    repeat (4) cyc();
    chk("t6_frozen_addr", int'(rd_addr0), 21);
    chk("t6_frozen_data", int'($signed(if0.out_data)), 20);
    ce = 1'b1;
    wait_done();
    chk("t6_count", hs_count, N);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
